// File: rtl/sum_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_chain_pkg
// Description : Shared helpers for the sum_chain_pipe operand-sum pipeline.
//               The stage payload structs depend on WIDTH, so they live
//               inside sum_chain_pipe; this package holds the
//               width-independent overflow helper.
// Revision    : 1.0  initial release
// ============================================================================
package sum_chain_pkg;

    // Overflow test for a sum evaluated on WIDTH+2 bits.
    // The caller passes the two bits above WIDTH. Any set bit means the true
    // sum did not fit in WIDTH bits.
    function automatic logic sum_ovf(input logic [1:0] i_hi);
        return |i_hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_chain_stage.sv
`default_nettype none
// ============================================================================
// Module      : sum_chain_stage
// Description : Generic valid/ready register slice. Loads when empty or when
//               downstream advances; holds payload and valid while stalled.
// Ports       : clk, rst (async, active-high)
//               i_valid / o_ready / i_payload  - upstream side
//               o_valid / i_adv   / o_payload  - downstream side (i_adv = ready)
// Revision    : 1.0  initial release
// ============================================================================
module sum_chain_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_payload,
    output logic          o_valid,
    input  logic          i_adv,
    output logic [PW-1:0] o_payload
);

    logic          r_valid;
    logic [PW-1:0] r_payload;
    logic          w_en;

    // The slice can take a new beat when it is empty or its beat leaves now.
    assign w_en = !r_valid | i_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (w_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_payload <= i_payload;
            end
        end
    end

    assign o_ready   = w_en;
    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule
`default_nettype wire

// File: rtl/sum_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sum_chain_pipe
// Description : Two-stage registered sum chain with valid/ready on both sides.
//               Stage 1 registers (a, b, c=a+b, carry). Stage 2 registers
//               d=a+b+c, f=c+d, and e (zero when a==ZERO_KEY, else f).
//               The block also provides a sticky overflow flag and a wrapping
//               handshake counter.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready/in_a/in_b          - operand pair input
//               out_valid/out_ready/out_c/d/f/e      - result output
//               ovf (sticky), done_cnt (output handshakes)
// Config      : SUM_CHAIN_FORCE_EN adds force_en/force_val. While force_en
//               is high, they override out_e combinationally.
// Revision    : 1.0  initial release
// ============================================================================
module sum_chain_pipe
    import sum_chain_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ZERO_KEY = 5,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_e,
    output logic             ovf,
    output logic [CNT_W-1:0] done_cnt
`ifdef SUM_CHAIN_FORCE_EN
    ,
    input  logic             force_en,
    input  logic [WIDTH-1:0] force_val
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             c1;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] e;
        logic             ovf_flag;
    } s2_t;

    s1_t              w_s1_in;
    s1_t              w_s1_q;
    s2_t              w_s2_in;
    s2_t              w_s2_q;
    logic             w_v1;
    logic             w_s2_ready;
    logic             w_emit;
    logic [WIDTH+1:0] w_d_full;
    logic [WIDTH+1:0] w_f_full;
    logic             r_ovf;
    logic [CNT_W-1:0] r_done_cnt;

    // ---------------- Stage 1 arithmetic: c = a + b with carry ----------------
    always_comb begin
        w_s1_in              = '0;
        w_s1_in.a            = in_a;
        w_s1_in.b            = in_b;
        {w_s1_in.c1, w_s1_in.c} = {1'b0, in_a} + {1'b0, in_b};
    end

    // ---------------- Stage 2 arithmetic: d, f, e and overflow ----------------
    // a+b+c fits in WIDTH+2 bits, so the two guard bits catch every overflow.
    assign w_d_full = {2'b00, w_s1_q.a} + {2'b00, w_s1_q.b} + {2'b00, w_s1_q.c};
    assign w_f_full = {2'b00, w_s1_q.c} + {2'b00, w_d_full[WIDTH-1:0]};

    always_comb begin
        w_s2_in          = '0;
        w_s2_in.c        = w_s1_q.c;
        w_s2_in.d        = w_d_full[WIDTH-1:0];
        w_s2_in.f        = w_f_full[WIDTH-1:0];
        w_s2_in.e        = (w_s1_q.a == WIDTH'(ZERO_KEY)) ? '0 : w_f_full[WIDTH-1:0];
        w_s2_in.ovf_flag = w_s1_q.c1
                         | sum_ovf(w_d_full[WIDTH+1:WIDTH])
                         | sum_ovf(w_f_full[WIDTH+1:WIDTH]);
    end

    // ---------------- Register slices ----------------
    // Stage 1 sees stage 2's ready as its advance, so in_ready = !v1 | adv2.
    sum_chain_stage #(.PW($bits(s1_t))) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (in_valid),
        .o_ready   (in_ready),
        .i_payload (w_s1_in),
        .o_valid   (w_v1),
        .i_adv     (w_s2_ready),
        .o_payload (w_s1_q)
    );

    sum_chain_stage #(.PW($bits(s2_t))) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_v1),
        .o_ready   (w_s2_ready),
        .i_payload (w_s2_in),
        .o_valid   (out_valid),
        .i_adv     (out_ready),
        .o_payload (w_s2_q)
    );

    // ---------------- Sticky overflow and handshake counter ----------------
    assign w_emit = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_done_cnt <= '0;
        end else if (w_emit) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
            if (w_s2_q.ovf_flag) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign out_c    = w_s2_q.c;
    assign out_d    = w_s2_q.d;
    assign out_f    = w_s2_q.f;
    assign ovf      = r_ovf;
    assign done_cnt = r_done_cnt;

`ifdef SUM_CHAIN_FORCE_EN
    // The override acts on the output only; the stored e is untouched, so
    // dropping force_en shows the computed value in the same cycle.
    assign out_e = force_en ? force_val : w_s2_q.e;
`else
    assign out_e = w_s2_q.e;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_chain_pipe
// Description : Self-checking bench for sum_chain_pipe. It uses a
//               transaction-level reference model. The model keeps a queue of
//               accepted pairs with their expected results and their age in
//               clock edges.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sum_chain_pipe;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
    localparam int ZK    = 5;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] e;
        bit               ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_c, out_d, out_f, out_e;
    logic             ovf;
    logic [CNT_W-1:0] done_cnt;
`ifdef SUM_CHAIN_FORCE_EN
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;
`endif

    always #5 clk = ~clk;

    sum_chain_pipe #(.WIDTH(WIDTH), .ZERO_KEY(ZK), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_f     (out_f),
        .out_e     (out_e),
        .ovf       (ovf),
        .done_cnt  (done_cnt)
`ifdef SUM_CHAIN_FORCE_EN
        ,
        .force_en  (force_en),
        .force_val (force_val)
`endif
    );

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t q[$];
    int   ages[$];
    int   exp_cnt    = 0;
    bit   exp_ovf    = 1'b0;
    bit   saw_block  = 1'b0;

    // Reference model: plain integer arithmetic on the stated sum rules.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t        r;
        longint      s_ab, s_abc, s_cd, m;
        m      = longint'(1) << WIDTH;
        s_ab   = longint'(a) + longint'(b);
        r.c    = WIDTH'(s_ab % m);
        s_abc  = longint'(a) + longint'(b) + longint'(r.c);
        r.d    = WIDTH'(s_abc % m);
        s_cd   = longint'(r.c) + longint'(r.d);
        r.f    = WIDTH'(s_cd % m);
        r.e    = (a == WIDTH'(ZK)) ? '0 : r.f;
        r.ovf  = (s_ab >= m) || (s_abc >= m) || (s_cd >= m);
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic run_cycle(input bit iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input bit ordy, output bit accepted);
        bit               exp_valid, exp_rdy, emit;
        exp_t             fr;
        logic [WIDTH-1:0] ee;
        logic [CNT_W-1:0] ecnt;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() > 0) && (ages[0] >= 1);
        exp_rdy   = (q.size() < 2) || ordy;
        ecnt      = CNT_W'(exp_cnt);
        vectors++;
        if (out_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
        end
        vectors++;
        if (in_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
        end
        vectors++;
        if (done_cnt !== ecnt) begin
            miscompares++;
            $display("FAIL done_cnt: got %0d expected %0d at %0t", done_cnt, ecnt, $time);
        end
        vectors++;
        if (ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL ovf: got %b expected %b at %0t", ovf, exp_ovf, $time);
        end
        if (exp_valid) begin
            fr = q[0];
            ee = fr.e;
`ifdef SUM_CHAIN_FORCE_EN
            if (force_en) ee = force_val;
`endif
            vectors++;
            if ({out_c, out_d, out_f, out_e} !== {fr.c, fr.d, fr.f, ee}) begin
                miscompares++;
                $display("FAIL data: got c=%h d=%h f=%h e=%h expected c=%h d=%h f=%h e=%h at %0t",
                         out_c, out_d, out_f, out_e, fr.c, fr.d, fr.f, ee, $time);
            end
        end
        if (!exp_rdy) saw_block = 1'b1;
        accepted = iv && exp_rdy;
        emit     = exp_valid && ordy;
        @(posedge clk);
        if (emit) begin
            exp_cnt++;
            exp_ovf = exp_ovf | q[0].ovf;
            void'(q.pop_front());
            void'(ages.pop_front());
        end
        foreach (ages[i]) ages[i] = ages[i] + 1;
        if (accepted) begin
            q.push_back(ref_model(a, b));
            ages.push_back(0);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        bit acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) run_cycle(1'b0, '0, '0, 1'b1, acc);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s drain: %0d results still pending, expected 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, ovf, done_cnt, out_c, out_d, out_f, out_e} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b ovf=%b cnt=%0d c=%h d=%h f=%h e=%h expected all 0",
                     out_valid, ovf, done_cnt, out_c, out_d, out_f, out_e);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit acc;
        run_cycle(1'b1, 16'd2, 16'd2, 1'b1, acc);
        run_cycle(1'b0, '0, '0, 1'b1, acc);
        #1;
        vectors++;
        if ({out_valid, out_c, out_d, out_f, out_e} !== {1'b1, 16'd4, 16'd8, 16'd12, 16'd12}) begin
            miscompares++;
            $display("FAIL basic_2_2: got v=%b c=%0d d=%0d f=%0d e=%0d expected v=1 c=4 d=8 f=12 e=12",
                     out_valid, out_c, out_d, out_f, out_e);
        end
        run_cycle(1'b0, '0, '0, 1'b1, acc);
        vectors++;
        if (done_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_zero_key();
        bit acc;
        run_cycle(1'b1, 16'd5, 16'd5, 1'b1, acc);
        run_cycle(1'b0, '0, '0, 1'b1, acc);
        #1;
        vectors++;
        if ({out_c, out_d, out_f, out_e} !== {16'd10, 16'd20, 16'd30, 16'd0}) begin
            miscompares++;
            $display("FAIL zero_key: got c=%0d d=%0d f=%0d e=%0d expected c=10 d=20 f=30 e=0",
                     out_c, out_d, out_f, out_e);
        end
        run_cycle(1'b0, '0, '0, 1'b1, acc);
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_key_ovf: got %b expected 0", ovf);
        end
    endtask

    task automatic test_overflow();
        bit acc;
        run_cycle(1'b1, 16'hFFFF, 16'd1, 1'b1, acc);
        run_cycle(1'b0, '0, '0, 1'b1, acc);
        #1;
        vectors++;
        if ({ovf, out_c, out_d, out_f, out_e} !== {1'b0, 64'd0}) begin
            miscompares++;
            $display("FAIL overflow_data: got ovf=%b c=%h d=%h f=%h e=%h expected ovf=0 all 0",
                     ovf, out_c, out_d, out_f, out_e);
        end
        run_cycle(1'b0, '0, '0, 1'b1, acc);
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b expected 1", ovf);
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 16'(i + 1), 16'(i + 3), 1'b1, acc);
        drain("overflow");
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: got %b expected 1", ovf);
        end
    endtask

    task automatic test_back_to_back();
        bit               acc;
        int               idx;
        int               start_cnt;
        logic [WIDTH-1:0] pa, pb;
        idx       = 0;
        start_cnt = exp_cnt;
        saw_block = 1'b0;
        pa        = WIDTH'($urandom);
        pb        = WIDTH'($urandom);
        for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
            run_cycle(1'b1, pa, pb, !(cyc >= 4 && cyc < 7), acc);
            if (acc) begin
                idx++;
                pa = WIDTH'($urandom);
                pb = WIDTH'($urandom);
            end
        end
        drain("back_to_back");
        vectors++;
        if (done_cnt !== CNT_W'(start_cnt + 10)) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d expected %0d", done_cnt, CNT_W'(start_cnt + 10));
        end
        vectors++;
        if (saw_block !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_backpressure: in_ready low observed=%b expected 1", saw_block);
        end
    endtask

    task automatic test_random();
        bit               acc;
        logic [WIDTH-1:0] a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? WIDTH'(ZK) : WIDTH'($urandom);
            run_cycle($urandom_range(0, 3) != 0, a, WIDTH'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        drain("random");
    endtask

    task automatic test_reset_midflight();
        bit acc;
        run_cycle(1'b1, 16'd7, 16'd9, 1'b0, acc);
        run_cycle(1'b1, 16'd3, 16'd4, 1'b0, acc);
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, ovf, done_cnt, out_c} !== '0) begin
            miscompares++;
            $display("FAIL midflight_reset: got v=%b ovf=%b cnt=%0d c=%h expected all 0",
                     out_valid, ovf, done_cnt, out_c);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        ages.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle(1'b0, '0, '0, 1'b1, acc);
    endtask

`ifdef SUM_CHAIN_FORCE_EN
    task automatic test_force();
        bit acc;
        force_en  = 1'b1;
        force_val = 16'hABCD;
        run_cycle(1'b1, 16'd2, 16'd2, 1'b0, acc);
        run_cycle(1'b0, '0, '0, 1'b0, acc);
        #1;
        vectors++;
        if ({out_e, out_f} !== {16'hABCD, 16'd12}) begin
            miscompares++;
            $display("FAIL force_on: got e=%h f=%0d expected e=abcd f=12", out_e, out_f);
        end
        force_en = 1'b0;
        #1;
        vectors++;
        if (out_e !== 16'd12) begin
            miscompares++;
            $display("FAIL force_off: got e=%0d expected 12", out_e);
        end
        drain("force");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_key();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_midflight();
`ifdef SUM_CHAIN_FORCE_EN
        test_force();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
